// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared combinational ALU: one operation in flight.
// Define ALU_ARB_FIXED_PRI_EN for fixed priority (requester 0 wins); default is round-robin.
//
// state | meaning
// IDLE  | waiting for a request; req_ready offered to the granted requester
// EXEC  | operands held on alu_x/alu_y/alu_ctl; ALU result captured at end of cycle
// RESP  | rsp_valid high; waiting for rsp_ready
module alu_arbiter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       req_valid,
   output logic [1:0]       req_ready,
   input  logic [WIDTH-1:0] req0_x,
   input  logic [WIDTH-1:0] req0_y,
   input  logic [WIDTH-1:0] req1_x,
   input  logic [WIDTH-1:0] req1_y,
   input  logic [5:0]       req0_op,
   input  logic [5:0]       req1_op,
   output logic [WIDTH-1:0] alu_x,
   output logic [WIDTH-1:0] alu_y,
   output logic [5:0]       alu_ctl,
   input  logic [WIDTH-1:0] alu_out,
   input  logic             alu_zr,
   input  logic             alu_ng,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_out,
   output logic             rsp_zr,
   output logic             rsp_ng
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t state;
   state_t state_nxt;

   logic gnt_any;
   logic gnt_id;
   logic accept;
   logic pend_id;

`ifdef ALU_ARB_FIXED_PRI_EN
   always_comb begin
      gnt_any = |req_valid;
      gnt_id  = ~req_valid[0];
   end
`else
   logic rr;

   always_comb begin
      gnt_any = |req_valid;
      if (&req_valid) gnt_id = rr;
      else            gnt_id = ~req_valid[0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr <= 1'b0;
      end else if (state == RESP && rsp_ready) begin
         rr <= ~rsp_id;
      end
   end
`endif

   // rst_n gates the offer so nothing is granted while reset is held
   always_comb begin
      req_ready = 2'b00;
      if (state == IDLE && rst_n && gnt_any) begin
         req_ready = gnt_id ? 2'b10 : 2'b01;
      end
   end

   assign accept    = |(req_valid & req_ready);
   assign rsp_valid = (state == RESP);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = EXEC;
         EXEC:    state_nxt = RESP;
         RESP:    if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_x   <= '0;
         alu_y   <= '0;
         alu_ctl <= 6'b000000;
         pend_id <= 1'b0;
         rsp_id  <= 1'b0;
         rsp_out <= '0;
         rsp_zr  <= 1'b0;
         rsp_ng  <= 1'b0;
      end else begin
         if (accept) begin
            alu_x   <= gnt_id ? req1_x  : req0_x;
            alu_y   <= gnt_id ? req1_y  : req0_y;
            alu_ctl <= gnt_id ? req1_op : req0_op;
            pend_id <= gnt_id;
         end
         if (state == EXEC) begin
            rsp_out <= alu_out;
            rsp_zr  <= alu_zr;
            rsp_ng  <= alu_ng;
            rsp_id  <= pend_id;
         end
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a behavioural Hack-style ALU on the alu_* port.
module tb_alu_arbiter;
   localparam int W = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [1:0]    req_valid = 2'b00;
   logic [1:0]    req_ready;
   logic [W-1:0]  req0_x = '0, req0_y = '0, req1_x = '0, req1_y = '0;
   logic [5:0]    req0_op = '0, req1_op = '0;
   logic [W-1:0]  alu_x, alu_y, alu_out;
   logic [5:0]    alu_ctl;
   logic          alu_zr, alu_ng;
   logic          rsp_valid;
   logic          rsp_ready = 1'b1;
   logic          rsp_id;
   logic [W-1:0]  rsp_out;
   logic          rsp_zr, rsp_ng;

   int total = 0;
   int bad = 0;

   typedef struct {
      logic         id;
      logic [W-1:0] out;
      logic         zr;
      logic         ng;
   } exp_t;
   exp_t q[$];

   alu_arbiter #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req0_x(req0_x), .req0_y(req0_y), .req1_x(req1_x), .req1_y(req1_y),
      .req0_op(req0_op), .req1_op(req1_op),
      .alu_x(alu_x), .alu_y(alu_y), .alu_ctl(alu_ctl),
      .alu_out(alu_out), .alu_zr(alu_zr), .alu_ng(alu_ng),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_out(rsp_out), .rsp_zr(rsp_zr), .rsp_ng(rsp_ng)
   );

   always #5 clk = ~clk;

   // external ALU: {zx,nx,zy,ny,f,no}
   always_comb begin
      logic [W-1:0] xa, ya, r;
      xa = alu_ctl[5] ? '0 : alu_x;
      xa = alu_ctl[4] ? ~xa : xa;
      ya = alu_ctl[3] ? '0 : alu_y;
      ya = alu_ctl[2] ? ~ya : ya;
      r  = alu_ctl[1] ? (xa + ya) : (xa & ya);
      r  = alu_ctl[0] ? ~r : r;
      alu_out = r;
      alu_zr  = (r == '0);
      alu_ng  = r[W-1];
   end

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // monitor: scoreboard pop, latency and hold-stability checks
   int rst_evt = 0;
   always @(negedge rst_n) rst_evt++;

   int   seen_rst = 0;
   int   age = 0;
   bit   tracking = 0;
   bit   held = 0;
   exp_t hold_v;

   always @(negedge clk) begin
      if (seen_rst != rst_evt) begin
         seen_rst = rst_evt;
         tracking = 0;
         held = 0;
      end
      if (tracking) begin
         age++;
         if (age == 1) chk("latency_exec", {7'd0, rsp_valid}, 8'd0);
         if (age == 2) begin
            chk("latency_resp", {7'd0, rsp_valid}, 8'd1);
            tracking = 0;
         end
      end
      if (held) begin
         chk("hold_valid", {7'd0, rsp_valid}, 8'd1);
         chk("hold_out", {4'd0, rsp_out}, {4'd0, hold_v.out});
         chk("hold_flags", {5'd0, rsp_id, rsp_zr, rsp_ng}, {5'd0, hold_v.id, hold_v.zr, hold_v.ng});
         held = 0;
      end
      if (rst_n && rsp_valid && !rsp_ready) begin
         held = 1;
         hold_v.id = rsp_id; hold_v.out = rsp_out; hold_v.zr = rsp_zr; hold_v.ng = rsp_ng;
      end
      if (rst_n && rsp_valid && rsp_ready) begin
         if (q.size() == 0) begin
            chk("unexpected_rsp", {7'd0, rsp_valid}, 8'd0);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("rsp_id", {7'd0, rsp_id}, {7'd0, e.id});
            chk("rsp_out", {4'd0, rsp_out}, {4'd0, e.out});
            chk("rsp_zr", {7'd0, rsp_zr}, {7'd0, e.zr});
            chk("rsp_ng", {7'd0, rsp_ng}, {7'd0, e.ng});
         end
      end
      if (rst_n && |(req_valid & req_ready)) begin
         tracking = 1;
         age = 0;
      end
   end

   task automatic reset_checks();
      chk("rst_req_ready", {6'd0, req_ready}, 8'd0);
      chk("rst_rsp_valid", {7'd0, rsp_valid}, 8'd0);
      chk("rst_alu_x", {4'd0, alu_x}, 8'd0);
      chk("rst_alu_y", {4'd0, alu_y}, 8'd0);
      chk("rst_alu_ctl", {2'd0, alu_ctl}, 8'd0);
      chk("rst_rsp", {2'd0, rsp_id, rsp_out, rsp_zr, rsp_ng}, 8'd0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req_valid = 2'b11;
      repeat (2) @(negedge clk);
      reset_checks();
      req_valid = 2'b00;
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   // returns one step after the accepting edge (DUT in EXEC)
   task automatic send(input bit id, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [5:0] op, input bit push,
                       input logic [W-1:0] eout, input bit ezr, input bit eng);
      bit got;
      exp_t e;
      if (id) begin req1_x = x; req1_y = y; req1_op = op; end
      else    begin req0_x = x; req0_y = y; req0_op = op; end
      if (push) begin
         e.id = id; e.out = eout; e.zr = ezr; e.ng = eng;
         q.push_back(e);
      end
      req_valid[id] = 1'b1;
      got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (req_ready[id]) got = 1;
      end
      if (!got) chk("accept_timeout", 8'd0, 8'd1);
      @(posedge clk); #1;
      req_valid[id] = 1'b0;
      chk("alu_x", {4'd0, alu_x}, {4'd0, x});
      chk("alu_y", {4'd0, alu_y}, {4'd0, y});
      chk("alu_ctl", {2'd0, alu_ctl}, {2'd0, op});
   endtask

   task automatic drain();
      bit done;
      done = 0;
      for (int i = 0; i < 40 && !done; i++) begin
         @(posedge clk); #1;
         if (q.size() == 0) done = 1;
      end
      if (!done) chk("drain_timeout", 8'd0, 8'd1);
   endtask

   initial begin
      exp_t e;
      do_reset();

      // AND: 1010 & 1100 = 1000
      send(1'b0, 4'b1010, 4'b1100, 6'b000000, 1'b1, 4'b1000, 1'b0, 1'b1);
      drain();
      // ADD: 0011 + 0101 = 1000
      send(1'b1, 4'b0011, 4'b0101, 6'b000010, 1'b1, 4'b1000, 1'b0, 1'b1);
      drain();

      // both valid from reset, constant-zero op
      do_reset();
      req0_x = 4'b1111; req0_y = 4'b0001; req0_op = 6'b101010;
      req1_x = 4'b0111; req1_y = 4'b1001; req1_op = 6'b101010;
      for (int k = 0; k < 4; k++) begin
`ifdef ALU_ARB_FIXED_PRI_EN
         e.id = 1'b0;
`else
         e.id = (k % 2 == 1);
`endif
         e.out = 4'b0000; e.zr = 1'b1; e.ng = 1'b0;
         q.push_back(e);
      end
      req_valid = 2'b11;
      drain();
      req_valid = 2'b00;
      repeat (2) @(posedge clk);
      #1;

      // stalled response: ~(0110 + 0011) = 0110
      rsp_ready = 1'b0;
      send(1'b0, 4'b0110, 4'b0011, 6'b000011, 1'b1, 4'b0110, 1'b0, 1'b0);
      req_valid = 2'b11;
      begin
         bit up;
         up = 0;
         for (int i = 0; i < 10 && !up; i++) begin
            @(negedge clk);
            if (rsp_valid) up = 1;
         end
         if (!up) chk("stall_resp_timeout", 8'd0, 8'd1);
      end
      for (int i = 0; i < 5; i++) begin
         chk("stall_req_ready", {6'd0, req_ready}, 8'd0);
         chk("stall_rsp_valid", {7'd0, rsp_valid}, 8'd1);
         if (i < 4) @(negedge clk);
      end
      @(posedge clk); #1;
      req_valid = 2'b00;
      rsp_ready = 1'b1;
      drain();

      // reset during EXEC discards the operation
      send(1'b1, 4'b1010, 4'b0101, 6'b000010, 1'b0, 4'b0000, 1'b0, 1'b0);
      rst_n = 1'b0;
      #2;
      reset_checks();
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("post_rst_rsp_valid", {7'd0, rsp_valid}, 8'd0);
      end
      @(posedge clk); #1;
      send(1'b0, 4'b0101, 4'b0011, 6'b000010, 1'b1, 4'b1000, 1'b0, 1'b1);
      drain();

      repeat (4) @(posedge clk);
      chk("queue_empty", q.size(), 8'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
